gen1_boot_core_tick_master: RTL and testbench
=============================================

# gen1_boot_core_tick_master

Avalon-MM initiator that owns the system timer's control port: programs its period, starts it in continuous mode with interrupts enabled, services each timeout interrupt by clearing status, and counts ticks. Sits between boot-core control logic and the timer slave (3-bit word address, 16-bit data, registered read data, no waitrequest), replacing CPU-driven tick servicing.

## Interface
- `MIN_PERIOD`, default 8: smallest period value written to the timer; smaller requests are clamped up to it.
- `clk`  in  1  system clock; shared with the timer slave.
- `reset`  in  1  asynchronous, active-high reset.
- `start`  in  1  one-cycle pulse: program the timer and run; honoured in IDLE only.
- `stop`  in  1  one-cycle pulse: halt the timer; ignored in IDLE.
- `cfg_period`  in  32  timer load value, cycles-minus-one; latched on an accepted `start`.
- `busy`  out  1  high from the first bus write until the stop write completes.
- `tick`  out  1  one-cycle pulse per serviced timeout.
- `tick_count`  out  32  serviced timeouts since the last accepted `start`; wraps.
- `snap_value`  out  32  timer counter snapshot; see Configuration.
- `snap_valid`  out  1  one-cycle pulse; `snap_value` updated.
- `avm_address`  out  3  word address: 0 status, 1 control, 2/3 period L/H, 4/5 snap L/H.
- `avm_chipselect`  out  1  transfer qualifier.
- `avm_write_n`  out  1  active-low write.
- `avm_writedata`  out  16  write data.
- `avm_readdata`  in  16  registered slave data, valid the cycle after the address.
- `irq`  in  1  timer interrupt, level, synchronous to `clk`.

## Operation
- Reset values: `busy`, `tick`, `snap_valid`, `avm_chipselect` 0; `avm_write_n` 1; `avm_address`, `avm_writedata`, `tick_count`, `snap_value` 0; state IDLE.
- States: IDLE, WR_PL, WR_PH, WR_GO, RUN, [SNAP_WR], CLR, [RD_L, RD_H, RD_W], WR_STOP.
- IDLE + `start`: latch max(`cfg_period`, `MIN_PERIOD`), clear `tick_count`, go to WR_PL.
- WR_PL writes period[15:0] to addr 2; WR_PH writes period[31:16] to addr 3; WR_GO writes 0x0007 (START, CONT, ITO) to addr 1. RUN follows.
- RUN + `irq`: go to CLR (or SNAP_WR when enabled). CLR writes 0x0000 to addr 0, pulses `tick` and increments `tick_count`, then returns to RUN.
- `stop` in RUN: go to WR_STOP, which writes 0x0008 (STOP) to addr 1, then IDLE.
- `stop` during WR_PL..WR_GO or the service states: latch it as pending and take the WR_STOP path on the next entry to RUN.
- Simultaneous `irq` and `stop` in RUN: service the tick first, then stop.
- `start` outside IDLE is ignored. `start` and `stop` together in IDLE: start wins.
- Bus drive: exactly one transfer per bus state, with `avm_chipselect` 1 that cycle. All bus outputs are registered. Read states drive `avm_write_n` 1. Idle bus: chipselect 0, write_n 1.

## Timing
- `start` in cycle 0: addr-2 write in cycle 1, addr-3 write in cycle 2, addr-1 write in cycle 3, RUN in cycle 4. `busy` is high from cycle 1.
- The timer's reload caused by the period writes coincides with the cycle-3 start write. The timer gives start precedence, so the counter runs.
- `irq` seen in RUN in cycle k (no snapshot): clear write and `tick` in cycle k+1, `tick_count` updated in k+2, RUN in k+2. `irq` is low by k+2.
- Stop: write in the cycle after `stop` is seen in RUN; `busy` falls the following cycle.
- Asserting `reset` mid-sequence abandons the transfer immediately. The timer is reset by the same reset.

## Configuration
- `TICK_MASTER_SNAPSHOT_EN` defined: per tick, SNAP_WR writes addr 4 in cycle k+1 and CLR runs in k+2. RD_L presents addr 4 in k+3. RD_H presents addr 5 in k+4 and captures the low half. RD_W captures the high half in k+5. `snap_valid` pulses in k+6, which is also the return to RUN.
- Undefined: snapshot states are absent; `snap_value` is 0 and `snap_valid` is 0.

## Structure
- Package `gen1_boot_core_systimer_pkg`:
  - register address constants;
  - control bit positions (ITO 0, CONT 1, START 2, STOP 3);
  - status bits (TO 0, RUN 1);
  - state enum.
- No sub-module: a single FSM with registered bus outputs.

## Test plan
- Reset: check every output's reset value and that the bus stays idle.
- `start` with `cfg_period`=0x0001_86A0 -> writes addr2=0x86A0, addr3=0x0001, addr1=0x0007 in cycles 1-3. Against the real timer, `irq` rises and `tick` occurs every 100001 cycles.
- `cfg_period`=3 -> written period is 8. Ten ticks leave `tick_count`=10 with no missed `irq`.
- `stop` in the same cycle as `irq` -> addr0 clear, then addr1=0x0008, then IDLE; `tick_count` is incremented once.
- `stop` during WR_PH -> completes WR_GO, then immediately WR_STOP; `busy` drops with no ticks counted.
- With the macro defined, the snapshot sequence hits addrs 4, 0, 4, 5. `snap_valid` pulses at k+6, and `snap_value` is within `cfg_period` minus a few cycles.

Source files
------------

// File: rtl/gen1_boot_core_systimer_pkg.sv
// Register map, control/status bit positions, bus record and FSM states shared by the tick master.
// TICK_MASTER_SNAPSHOT_EN adds the counter-snapshot states to the state set.
package gen1_boot_core_systimer_pkg;

  localparam logic [2:0] ADDR_STATUS   = 3'd0;
  localparam logic [2:0] ADDR_CONTROL  = 3'd1;
  localparam logic [2:0] ADDR_PERIOD_L = 3'd2;
  localparam logic [2:0] ADDR_PERIOD_H = 3'd3;
  localparam logic [2:0] ADDR_SNAP_L   = 3'd4;
  localparam logic [2:0] ADDR_SNAP_H   = 3'd5;

  localparam int CTRL_ITO   = 0;
  localparam int CTRL_CONT  = 1;
  localparam int CTRL_START = 2;
  localparam int CTRL_STOP  = 3;

  localparam int STAT_TO  = 0;
  localparam int STAT_RUN = 1;

  localparam logic [15:0] CTRL_GO   = 16'((1 << CTRL_START) | (1 << CTRL_CONT) | (1 << CTRL_ITO));
  localparam logic [15:0] CTRL_HALT = 16'(1 << CTRL_STOP);
  localparam logic [15:0] STAT_CLR  = 16'h0000;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_WR_PL,
    ST_WR_PH,
    ST_WR_GO,
    ST_RUN,
    ST_CLR,
    ST_WR_STOP
`ifdef TICK_MASTER_SNAPSHOT_EN
    ,
    ST_SNAP_WR,
    ST_RD_L,
    ST_RD_H,
    ST_RD_W
`endif
  } state_t;

  typedef struct packed {
    logic        cs;
    logic        wr_n;
    logic [2:0]  addr;
    logic [15:0] data;
  } bus_t;

  function automatic bus_t bus_wr(input logic [2:0] addr, input logic [15:0] data);
    return '{cs: 1'b1, wr_n: 1'b0, addr: addr, data: data};
  endfunction

  function automatic bus_t bus_rd(input logic [2:0] addr);
    return '{cs: 1'b1, wr_n: 1'b1, addr: addr, data: 16'h0000};
  endfunction

endpackage

// File: rtl/gen1_boot_core_tick_master.sv
// Avalon-MM initiator that programs the system timer, services its timeout IRQs and counts ticks.
// Define TICK_MASTER_SNAPSHOT_EN to read back a counter snapshot on every serviced tick.
module gen1_boot_core_tick_master
  import gen1_boot_core_systimer_pkg::*;
#(
  parameter int MIN_PERIOD = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        stop,
  input  logic [31:0] cfg_period,
  output logic        busy,
  output logic        tick,
  output logic [31:0] tick_count,
  output logic [31:0] snap_value,
  output logic        snap_valid,
  output logic [2:0]  avm_address,
  output logic        avm_chipselect,
  output logic        avm_write_n,
  output logic [15:0] avm_writedata,
  input  logic [15:0] avm_readdata,
  input  logic        irq
);

  localparam logic [31:0] MIN_PERIOD_W = 32'(MIN_PERIOD);

  function automatic logic [31:0] clamp_period(input logic [31:0] p);
    return (p < MIN_PERIOD_W) ? MIN_PERIOD_W : p;
  endfunction

  state_t      state;
  bus_t        bus;
  logic [31:0] period;
  logic [31:0] period_req;
  logic        stop_pend;
  logic        stop_now;

  assign period_req     = clamp_period(cfg_period);
  // A stop seen while the bus is busy is honoured at the next point the FSM would re-enter RUN.
  assign stop_now       = stop_pend | stop;

  assign avm_chipselect = bus.cs;
  assign avm_write_n    = bus.wr_n;
  assign avm_address    = bus.addr;
  assign avm_writedata  = bus.data;

  always_ff @(posedge clk) begin
    if (state == ST_IDLE && start) period <= period_req;
  end

`ifdef TICK_MASTER_SNAPSHOT_EN
  logic [15:0] snap_lo;

  always_ff @(posedge clk) begin
    if (state == ST_RD_H) snap_lo <= avm_readdata;
  end
`else
  logic unused_readdata;

  assign unused_readdata = ^avm_readdata;
  assign snap_value      = '0;
  assign snap_valid      = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= ST_IDLE;
      bus        <= '{cs: 1'b0, wr_n: 1'b1, addr: 3'd0, data: 16'h0000};
      busy       <= 1'b0;
      tick       <= 1'b0;
      tick_count <= '0;
      stop_pend  <= 1'b0;
`ifdef TICK_MASTER_SNAPSHOT_EN
      snap_value <= '0;
      snap_valid <= 1'b0;
`endif
    end else begin
      bus.cs     <= 1'b0;
      bus.wr_n   <= 1'b1;
      tick       <= 1'b0;
`ifdef TICK_MASTER_SNAPSHOT_EN
      snap_valid <= 1'b0;
`endif
      case (state)
        ST_IDLE: begin
          if (start) begin
            busy       <= 1'b1;
            tick_count <= '0;
            stop_pend  <= 1'b0;
            bus        <= bus_wr(ADDR_PERIOD_L, period_req[15:0]);
            state      <= ST_WR_PL;
          end
        end
        ST_WR_PL: begin
          stop_pend <= stop_now;
          bus       <= bus_wr(ADDR_PERIOD_H, period[31:16]);
          state     <= ST_WR_PH;
        end
        ST_WR_PH: begin
          stop_pend <= stop_now;
          bus       <= bus_wr(ADDR_CONTROL, CTRL_GO);
          state     <= ST_WR_GO;
        end
        ST_WR_GO: begin
          if (stop_now) begin
            stop_pend <= 1'b0;
            bus       <= bus_wr(ADDR_CONTROL, CTRL_HALT);
            state     <= ST_WR_STOP;
          end else begin
            state <= ST_RUN;
          end
        end
        ST_RUN: begin
          // Servicing wins over a simultaneous stop; the stop is carried as pending.
          if (irq) begin
            stop_pend <= stop;
`ifdef TICK_MASTER_SNAPSHOT_EN
            bus       <= bus_wr(ADDR_SNAP_L, 16'h0000);
            state     <= ST_SNAP_WR;
`else
            bus       <= bus_wr(ADDR_STATUS, STAT_CLR);
            tick      <= 1'b1;
            state     <= ST_CLR;
`endif
          end else if (stop) begin
            bus   <= bus_wr(ADDR_CONTROL, CTRL_HALT);
            state <= ST_WR_STOP;
          end
        end
`ifdef TICK_MASTER_SNAPSHOT_EN
        ST_SNAP_WR: begin
          stop_pend <= stop_now;
          bus       <= bus_wr(ADDR_STATUS, STAT_CLR);
          tick      <= 1'b1;
          state     <= ST_CLR;
        end
        ST_CLR: begin
          stop_pend  <= stop_now;
          tick_count <= tick_count + 32'd1;
          bus        <= bus_rd(ADDR_SNAP_L);
          state      <= ST_RD_L;
        end
        ST_RD_L: begin
          stop_pend <= stop_now;
          bus       <= bus_rd(ADDR_SNAP_H);
          state     <= ST_RD_H;
        end
        ST_RD_H: begin
          stop_pend <= stop_now;
          state     <= ST_RD_W;
        end
        ST_RD_W: begin
          snap_value <= {avm_readdata, snap_lo};
          snap_valid <= 1'b1;
          if (stop_now) begin
            stop_pend <= 1'b0;
            bus       <= bus_wr(ADDR_CONTROL, CTRL_HALT);
            state     <= ST_WR_STOP;
          end else begin
            state <= ST_RUN;
          end
        end
`else
        ST_CLR: begin
          tick_count <= tick_count + 32'd1;
          if (stop_now) begin
            stop_pend <= 1'b0;
            bus       <= bus_wr(ADDR_CONTROL, CTRL_HALT);
            state     <= ST_WR_STOP;
          end else begin
            state <= ST_RUN;
          end
        end
`endif
        ST_WR_STOP: begin
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_gen1_boot_core_tick_master.sv
// Directed bench for the tick master against a behavioural system-timer slave, with a bus-transfer scoreboard.
// Define TICK_MASTER_SNAPSHOT_EN for both DUT and bench to exercise the snapshot sequence.
module tb_gen1_boot_core_tick_master;

  typedef struct packed {
    logic [2:0]  addr;
    logic        wr_n;
    logic [15:0] data;
  } xfer_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic [31:0] cfg_period = '0;
  logic        busy, tick, snap_valid, avm_chipselect, avm_write_n, irq;
  logic [31:0] tick_count, snap_value;
  logic [2:0]  avm_address;
  logic [15:0] avm_writedata, avm_readdata;

  gen1_boot_core_tick_master #(.MIN_PERIOD(8)) dut (
    .clk(clk), .reset(reset), .start(start), .stop(stop), .cfg_period(cfg_period),
    .busy(busy), .tick(tick), .tick_count(tick_count), .snap_value(snap_value),
    .snap_valid(snap_valid), .avm_address(avm_address), .avm_chipselect(avm_chipselect),
    .avm_write_n(avm_write_n), .avm_writedata(avm_writedata), .avm_readdata(avm_readdata),
    .irq(irq)
  );

  always #5 clk = ~clk;

  // Behavioural timer slave: period/control/status/snapshot, registered read data.
  logic [31:0] t_period, t_cnt, t_snap;
  logic        t_run, t_cont, t_ito, t_to;
  logic [15:0] t_rdata;
  int          t_timeouts;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      t_period <= '0; t_cnt <= '0; t_snap <= '0; t_rdata <= '0;
      t_run <= 1'b0; t_cont <= 1'b0; t_ito <= 1'b0; t_to <= 1'b0; t_timeouts <= 0;
    end else begin
      t_rdata <= 16'h0;
      if (avm_chipselect && avm_write_n)
        case (avm_address)
          3'd0: t_rdata <= {14'h0, t_run, t_to};
          3'd4: t_rdata <= t_snap[15:0];
          3'd5: t_rdata <= t_snap[31:16];
          default: ;
        endcase
      if (t_run) begin
        if (t_cnt == 0) begin
          t_to <= 1'b1; t_timeouts <= t_timeouts + 1; t_cnt <= t_period; t_run <= t_cont;
        end else begin
          t_cnt <= t_cnt - 1;
        end
      end
      if (avm_chipselect && !avm_write_n)
        case (avm_address)
          3'd0: t_to <= 1'b0;
          3'd1: begin
            if (avm_writedata[3]) t_run <= 1'b0;
            else if (avm_writedata[2]) begin
              t_run <= 1'b1; t_cont <= avm_writedata[1]; t_ito <= avm_writedata[0]; t_cnt <= t_period;
            end
          end
          3'd2: t_period[15:0] <= avm_writedata;
          3'd3: t_period[31:16] <= avm_writedata;
          3'd4: t_snap <= t_cnt;
          default: ;
        endcase
    end
  end

  assign irq          = t_to & t_ito;
  assign avm_readdata = t_rdata;

  xfer_t sb[$];
  int checks = 0;
  int passes = 0;
  int cyc_n = 0;
  int ticks_seen = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic push(input logic [2:0] addr, input logic wr_n, input logic [15:0] data);
    xfer_t x;
    x.addr = addr; x.wr_n = wr_n; x.data = data;
    sb.push_back(x);
  endtask

  task automatic push_service();
`ifdef TICK_MASTER_SNAPSHOT_EN
    push(3'd4, 1'b0, 16'h0000);
    push(3'd0, 1'b0, 16'h0000);
    push(3'd4, 1'b1, 16'h0000);
    push(3'd5, 1'b1, 16'h0000);
`else
    push(3'd0, 1'b0, 16'h0000);
`endif
  endtask

  // Advance one cycle and score any transfer the DUT presents in the new cycle.
  task automatic step();
    xfer_t got, exp;
    @(posedge clk);
    #1;
    cyc_n++;
    if (tick) ticks_seen++;
    if (avm_chipselect) begin
      got.addr = avm_address;
      got.wr_n = avm_write_n;
      got.data = avm_write_n ? 16'h0 : avm_writedata;
      if (sb.size() == 0) begin
        chk("unexpected_xfer", avm_chipselect, 1'b0);
      end else begin
        exp = sb.pop_front();
        chk("xfer", got, exp);
      end
    end
  endtask

  task automatic wait_tick(input int budget);
    int n = 0;
    do begin
      step();
      n++;
    end while (!tick && n < budget);
    chk("tick_timeout", tick, 1'b1);
    chk("tick_with_clear", {avm_chipselect, avm_write_n, avm_address}, {1'b1, 1'b0, 3'd0});
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while (busy && n < budget) begin
      step();
      n++;
    end
    chk("busy_fall_timeout", busy, 1'b0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int prev, base_to, base_ticks, n;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ctrl", {busy, tick, snap_valid, avm_chipselect, avm_write_n}, 5'b00001);
    chk("rst_addr_data", {avm_address, avm_writedata}, 19'h0);
    chk("rst_count", tick_count, 32'h0);
    chk("rst_snap", snap_value, 32'h0);
    reset = 1'b0;
    repeat (5) step();
    chk("idle_bus", {avm_chipselect, avm_write_n, busy}, 3'b010);

    // Large period: programming sequence, then stop from RUN
    cfg_period = 32'h0001_86A0;
    start = 1'b1;
    push(3'd2, 1'b0, 16'h86A0); push(3'd3, 1'b0, 16'h0001); push(3'd1, 1'b0, 16'h0007);
    step(); start = 1'b0;
    chk("a_c1_busy", busy, 1'b1);
    chk("a_c1_write", {avm_chipselect, avm_address}, {1'b1, 3'd2});
    step(); step();
    chk("a_c3_write", {avm_chipselect, avm_address, avm_writedata}, {1'b1, 3'd1, 16'h0007});
    step();
    chk("a_c4_run_idle", {avm_chipselect, busy}, 2'b01);
    repeat (20) step();
    stop = 1'b1;
    push(3'd1, 1'b0, 16'h0008);
    step(); stop = 1'b0;
    chk("a_stop_write", {avm_chipselect, avm_address, avm_writedata, busy}, {1'b1, 3'd1, 16'h0008, 1'b1});
    step();
    chk("a_busy_fall", busy, 1'b0);
    chk("a_no_ticks", tick_count, 32'h0);

    // Clamped period: ten ticks, start ignored while running
    cfg_period = 32'd3;
    start = 1'b1;
    push(3'd2, 1'b0, 16'h0008); push(3'd3, 1'b0, 16'h0000); push(3'd1, 1'b0, 16'h0007);
    step(); start = 1'b0;
    step(); step(); step();
    base_to = t_timeouts;
    base_ticks = ticks_seen;
    prev = 0;
    for (int i = 0; i < 10; i++) begin
      push_service();
      if (i == 3) begin
        start = 1'b1; step(); start = 1'b0;
      end
      wait_tick(40);
      if (i > 0) chk("b_interval", cyc_n - prev, 9);
      prev = cyc_n;
      step();
      chk("b_count", tick_count, i + 1);
`ifdef TICK_MASTER_SNAPSHOT_EN
      step(); step();
      chk("b_snap_early", snap_valid, 1'b0);
      step();
      chk("b_snap_valid", snap_valid, 1'b1);
      chk("b_snap_value", snap_value, 32'd7);
`endif
    end
    chk("b_no_missed_irq", t_timeouts - base_to, 10);
    chk("b_ticks_seen", ticks_seen - base_ticks, 10);
    stop = 1'b1;
    push(3'd1, 1'b0, 16'h0008);
    step(); stop = 1'b0;
    chk("b_stop_write", {avm_chipselect, avm_address}, {1'b1, 3'd1});
    step();
    chk("b_busy_fall", busy, 1'b0);
    chk("b_sb_drained", sb.size(), 0);

    // start+stop together in IDLE (start wins), then stop coincident with irq
    cfg_period = 32'd20;
    start = 1'b1; stop = 1'b1;
    push(3'd2, 1'b0, 16'h0014); push(3'd3, 1'b0, 16'h0000); push(3'd1, 1'b0, 16'h0007);
    step(); start = 1'b0; stop = 1'b0;
    step(); step(); step();
    chk("c_running", {busy, avm_chipselect}, 2'b10);
    n = 0;
    do begin
      step();
      n++;
    end while (!irq && n < 60);
    chk("c_irq_seen", irq, 1'b1);
    base_ticks = ticks_seen;
    stop = 1'b1;
    push_service();
    push(3'd1, 1'b0, 16'h0008);
    step(); stop = 1'b0;
`ifndef TICK_MASTER_SNAPSHOT_EN
    chk("c_tick_k1", tick, 1'b1);
    step();
    chk("c_stop_k2", {avm_chipselect, avm_address, avm_writedata}, {1'b1, 3'd1, 16'h0008});
`endif
    wait_idle(20);
    chk("c_count", tick_count, 32'd1);
    chk("c_ticks_seen", ticks_seen - base_ticks, 1);
    chk("c_sb_drained", sb.size(), 0);

    // stop during WR_PH: WR_GO then straight to WR_STOP
    cfg_period = 32'd50;
    start = 1'b1;
    push(3'd2, 1'b0, 16'h0032); push(3'd3, 1'b0, 16'h0000); push(3'd1, 1'b0, 16'h0007);
    push(3'd1, 1'b0, 16'h0008);
    base_ticks = ticks_seen;
    step(); start = 1'b0;
    step(); stop = 1'b1;
    step(); stop = 1'b0;
    step();
    chk("d_stop_c4", {avm_chipselect, avm_address, avm_writedata}, {1'b1, 3'd1, 16'h0008});
    step();
    chk("d_busy_fall_c5", busy, 1'b0);
    repeat (30) step();
    chk("d_no_ticks", {tick_count, 32'(ticks_seen - base_ticks)}, 64'h0);
    chk("d_sb_drained", sb.size(), 0);

    // Reset mid-sequence abandons the transfer at once
    cfg_period = 32'd30;
    start = 1'b1;
    push(3'd2, 1'b0, 16'h001E); push(3'd3, 1'b0, 16'h0000); push(3'd1, 1'b0, 16'h0007);
    step(); start = 1'b0;
    step();
    reset = 1'b1;
    #1;
    chk("e_rst_async", {avm_chipselect, avm_write_n, busy, avm_address}, {3'b010, 3'd0});
    sb.delete();
    @(posedge clk);
    #1;
    reset = 1'b0;
    repeat (10) step();
    chk("e_idle_after", {busy, avm_chipselect, tick_count}, 34'h0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
